// File: rtl/ahb_lite_des_master.sv
// AHB-Lite master that loads a Triple DES core: five pipelined 64-bit writes
// (mode, key1..3, data), a programmable idle gap, then one read of the result.
module ahb_lite_des_master #(
  parameter int unsigned WAIT_CYCLES = 20
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        start,
  input  logic        encryptionType,
  input  logic [63:0] key1,
  input  logic [63:0] key2,
  input  logic [63:0] key3,
  input  logic [63:0] dataIn,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [63:0] result,
  output logic        HSEL,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [63:0] HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [63:0] HRDATA,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_WAIT    = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_DATA = 3'd4,
    S_ERR     = 3'd5
  } state_e;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYCLES - 1);

  state_e      state_q;
  logic [2:0]  beat_q;
  logic [7:0]  wait_q;
  logic        enc_q;
  logic [63:0] key1_q, key2_q, key3_q, data_q;
  logic        busy_q, done_q, error_q;
  logic [63:0] result_q;
  logic        hsel_q, hwrite_q;
  logic [1:0]  htrans_q;
  logic [31:0] haddr_q;
  logic [63:0] hwdata_q;

  // Beat k targets register k of the core, spaced 0x400 apart.
  function automatic logic [31:0] beat_addr(input logic [2:0] k);
    return {19'd0, k, 10'd0};
  endfunction

  function automatic logic [63:0] beat_word(input logic [2:0] k);
    case (k)
      3'd0:    return {63'd0, enc_q};
      3'd1:    return key1_q;
      3'd2:    return key2_q;
      3'd3:    return key3_q;
      default: return data_q;
    endcase
  endfunction

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      wait_q   <= '0;
      enc_q    <= 1'b0;
      key1_q   <= '0;
      key2_q   <= '0;
      key3_q   <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      result_q <= '0;
      hsel_q   <= 1'b0;
      hwrite_q <= 1'b0;
      htrans_q <= TR_IDLE;
      haddr_q  <= '0;
      hwdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A start in the same cycle as the done pulse is deliberately dropped.
          if (start && !done_q) begin
            enc_q    <= encryptionType;
            key1_q   <= key1;
            key2_q   <= key2;
            key3_q   <= key3;
            data_q   <= dataIn;
            busy_q   <= 1'b1;
            error_q  <= 1'b0;
            beat_q   <= 3'd0;
            htrans_q <= TR_NONSEQ;
            hsel_q   <= 1'b1;
            haddr_q  <= beat_addr(3'd0);
            hwrite_q <= 1'b1;
            state_q  <= S_WRITE;
          end
        end
        S_WRITE: begin
          // beat_q = beat currently in its address phase; 5 means only the
          // final data phase is still outstanding.
          if (HRESP && !HREADY) begin
            htrans_q <= TR_IDLE;
            hsel_q   <= 1'b0;
            beat_q   <= '0;
            state_q  <= S_ERR;
          end else if (HREADY) begin
            if (beat_q < 3'd4) begin
              haddr_q  <= beat_addr(beat_q + 3'd1);
              hwdata_q <= beat_word(beat_q);
              beat_q   <= beat_q + 3'd1;
            end else if (beat_q == 3'd4) begin
              htrans_q <= TR_IDLE;
              hsel_q   <= 1'b0;
              hwdata_q <= beat_word(3'd4);
              beat_q   <= 3'd5;
            end else begin
              beat_q  <= '0;
              wait_q  <= '0;
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            htrans_q <= TR_NONSEQ;
            hsel_q   <= 1'b1;
            haddr_q  <= beat_addr(3'd4);
            hwrite_q <= 1'b0;
            state_q  <= S_RD_ADDR;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        S_RD_ADDR: begin
          if (HREADY) begin
            htrans_q <= TR_IDLE;
            hsel_q   <= 1'b0;
            state_q  <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (HRESP && !HREADY) begin
            state_q <= S_ERR;
          end else if (HREADY) begin
            result_q <= HRDATA;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        S_ERR: begin
          if (HREADY) begin
            done_q  <= 1'b1;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign result    = result_q;
  assign HSEL      = hsel_q;
  assign HADDR     = haddr_q;
  assign HWRITE    = hwrite_q;
  assign HTRANS    = htrans_q;
  assign HWDATA    = hwdata_q;
  assign HSIZE     = 3'b011;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'h1;
  assign HMASTLOCK = 1'b0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ahb_lite_des_master.sv
// Directed bench for ahb_lite_des_master: cycle-exact timeline, wait-state
// stall, error response, ignored starts and asynchronous reset in WAIT.
module tb_ahb_lite_des_master;

  // Handshake: an address or data phase completes on a rising edge with HREADY=1;
  // HRESP=1 with HREADY=0 is the first cycle of a two-cycle error response.

  logic        clk, rst_n;
  logic        start, enc;
  logic [63:0] k1, k2, k3, din;
  logic        busy, done, error;
  logic [63:0] result;
  logic        hsel, hwrite, hmastlock;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [63:0] hwdata;
  logic        hready, hresp;
  logic [63:0] hrdata;
  logic [2:0]  dbg_state;

  int vectors = 0;
  int miscompares = 0;

  ahb_lite_des_master #(.WAIT_CYCLES(4)) dut (
    .HCLK(clk), .HRESET(rst_n), .start(start), .encryptionType(enc),
    .key1(k1), .key2(k2), .key3(k3), .dataIn(din),
    .busy(busy), .done(done), .error(error), .result(result),
    .HSEL(hsel), .HADDR(haddr), .HWRITE(hwrite), .HTRANS(htrans),
    .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HMASTLOCK(hmastlock),
    .HWDATA(hwdata), .HREADY(hready), .HRESP(hresp), .HRDATA(hrdata),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus monitor: logs completed transfers and done pulses, sampled mid-cycle.
  logic [32:0] addr_log[$];
  logic [63:0] data_log[$];
  int          done_cnt = 0;
  bit          pend_wr = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend_wr = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (pend_wr && hready) begin
        if (!hresp) data_log.push_back(hwdata);
        pend_wr = 1'b0;
      end
      if (htrans == 2'b10 && hready) begin
        addr_log.push_back({hwrite, haddr});
        pend_wr = hwrite;
      end
    end
  end

  // Scoreboard
  logic [63:0] exp_q[$];
  logic [32:0] exp_a_q[$];
  logic [63:0] words[5];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    addr_log.delete();
    data_log.delete();
    done_cnt = 0;
  endtask

  // Drivers
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at 1 time unit after the accepting edge E0.
  task automatic do_start(input logic e, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] c, input logic [63:0] d);
    enc = e; k1 = a; k2 = b; k3 = c; din = d;
    words[0] = {63'd0, e};
    words[1] = a;
    words[2] = b;
    words[3] = c;
    words[4] = d;
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic expect_full();
    exp_a_q.delete();
    exp_q.delete();
    for (int k = 0; k < 5; k++) begin
      exp_a_q.push_back({1'b1, 32'h400 * 32'(k)});
      exp_q.push_back(words[k]);
    end
    exp_a_q.push_back({1'b0, 32'h1000});
  endtask

  task automatic check_logs(input string tag);
    chk({tag, " addr count"}, 64'(addr_log.size()), 64'(exp_a_q.size()));
    chk({tag, " data count"}, 64'(data_log.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_a_q.size() && i < addr_log.size(); i++)
      chk($sformatf("%s addr%0d", tag, i), 64'(addr_log[i]), 64'(exp_a_q[i]));
    for (int i = 0; i < exp_q.size() && i < data_log.size(); i++)
      chk($sformatf("%s data%0d", tag, i), data_log[i], exp_q[i]);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (done) break;
    end
    chk({tag, " done seen"}, 64'(done), 64'd1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " htrans"}, 64'(htrans), 64'd0);
    chk({tag, " hsel"},   64'(hsel),   64'd0);
    chk({tag, " haddr"},  64'(haddr),  64'd0);
    chk({tag, " hwrite"}, 64'(hwrite), 64'd0);
    chk({tag, " hwdata"}, hwdata,      64'd0);
    chk({tag, " busy"},   64'(busy),   64'd0);
    chk({tag, " done"},   64'(done),   64'd0);
    chk({tag, " error"},  64'(error),  64'd0);
    chk({tag, " result"}, result,      64'd0);
    chk({tag, " state"},  64'(dbg_state), 64'd0);
  endtask

  logic [63:0] prev_result;
  logic [1:0]  exp_tr;

  initial begin
    rst_n = 1'b0; start = 1'b0; enc = 1'b0;
    k1 = '0; k2 = '0; k3 = '0; din = '0;
    hready = 1'b1; hresp = 1'b0; hrdata = '0;

    // Reset state and tied-off signals
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    chk("hsize",     64'(hsize),     64'h3);
    chk("hburst",    64'(hburst),    64'h0);
    chk("hprot",     64'(hprot),     64'h1);
    chk("hmastlock", 64'(hmastlock), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Cycle-exact timeline with zero wait states
    clear_logs();
    hrdata = 64'hDEAD_BEEF_0123_4567;
    do_start(1'b1, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
             64'h9999_AAAA_BBBB_CCCC, 64'h0123_4567_89AB_CDEF);
    for (int c = 0; c <= 13; c++) begin
      if (c > 0) cycle();
      exp_tr = (c <= 4 || c == 10) ? 2'b10 : 2'b00;
      chk($sformatf("t2 htrans c%0d", c), 64'(htrans), 64'(exp_tr));
      chk($sformatf("t2 hsel c%0d", c), 64'(hsel), 64'(exp_tr == 2'b10));
      chk($sformatf("t2 busy c%0d", c), 64'(busy), 64'(c <= 11));
      chk($sformatf("t2 done c%0d", c), 64'(done), 64'(c == 12));
      if (c <= 4) begin
        chk($sformatf("t2 haddr c%0d", c), 64'(haddr), 64'(32'h400 * 32'(c)));
        chk($sformatf("t2 hwrite c%0d", c), 64'(hwrite), 64'd1);
      end
      if (c == 10) begin
        chk("t2 rd haddr", 64'(haddr), 64'h1000);
        chk("t2 rd hwrite", 64'(hwrite), 64'd0);
      end
      if (c >= 1 && c <= 5)
        chk($sformatf("t2 hwdata c%0d", c), hwdata, words[c-1]);
      if (c == 12) begin
        chk("t2 result", result, 64'hDEAD_BEEF_0123_4567);
        chk("t2 error", 64'(error), 64'd0);
      end
    end
    expect_full();
    check_logs("t2");
    chk("t2 done pulses", 64'(done_cnt), 64'd1);

    // Three wait states during the key2 data phase
    repeat (2) cycle();
    clear_logs();
    hrdata = 64'h0F0F_F0F0_1357_9BDF;
    do_start(1'b0, 64'hAAAA_0000_0000_0001, 64'hA5A5_0000_FFFF_1234,
             64'hC3C3_3C3C_0000_0002, 64'h7777_8888_9999_0000);
    repeat (3) cycle();
    hready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if (s > 0) cycle();
      chk($sformatf("t3 stall haddr s%0d", s), 64'(haddr), 64'h0C00);
      chk($sformatf("t3 stall hwdata s%0d", s), hwdata, 64'hA5A5_0000_FFFF_1234);
      chk($sformatf("t3 stall htrans s%0d", s), 64'(htrans), 64'h2);
    end
    hready = 1'b1;
    wait_done("t3");
    chk("t3 result", result, 64'h0F0F_F0F0_1357_9BDF);
    chk("t3 error", 64'(error), 64'd0);
    repeat (2) cycle();
    expect_full();
    check_logs("t3");
    chk("t3 done pulses", 64'(done_cnt), 64'd1);

    // start while busy, and start coinciding with done, are both ignored
    clear_logs();
    hrdata = 64'h2468_ACE0_1357_9BDF;
    do_start(1'b1, 64'h0000_0000_0000_0011, 64'h0000_0000_0000_0022,
             64'h0000_0000_0000_0033, 64'h0000_0000_0000_0044);
    for (int c = 1; c <= 11; c++) begin
      cycle();
      start = (c == 2 || c == 8 || c == 11);
    end
    cycle();
    start = 1'b0;
    chk("t4 done at c12", 64'(done), 64'd1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("t4 busy after done-start", 64'(busy), 64'd0);
    chk("t4 htrans after done-start", 64'(htrans), 64'd0);
    chk("t4 state after done-start", 64'(dbg_state), 64'd0);
    repeat (20) cycle();
    expect_full();
    check_logs("t4");
    chk("t4 done pulses", 64'(done_cnt), 64'd1);
    chk("t4 result", result, 64'h2468_ACE0_1357_9BDF);

    // Two-cycle ERROR response on the 0x400 beat
    prev_result = 64'h2468_ACE0_1357_9BDF;
    clear_logs();
    hrdata = 64'hBAD0_BAD0_BAD0_BAD0;
    do_start(1'b1, 64'hE1E1_E1E1_E1E1_E1E1, 64'hE2E2_E2E2_E2E2_E2E2,
             64'hE3E3_E3E3_E3E3_E3E3, 64'hE4E4_E4E4_E4E4_E4E4);
    repeat (2) cycle();
    hready = 1'b0;
    hresp = 1'b1;
    chk("t5 err1 htrans", 64'(htrans), 64'h2);
    cycle();
    hready = 1'b1;
    chk("t5 err2 htrans", 64'(htrans), 64'h0);
    chk("t5 err2 hsel", 64'(hsel), 64'h0);
    chk("t5 err2 busy", 64'(busy), 64'h1);
    cycle();
    hresp = 1'b0;
    chk("t5 done", 64'(done), 64'd1);
    chk("t5 error", 64'(error), 64'd1);
    chk("t5 busy", 64'(busy), 64'd0);
    chk("t5 result kept", result, prev_result);
    repeat (12) cycle();
    exp_a_q.delete();
    exp_q.delete();
    exp_a_q.push_back({1'b1, 32'h0});
    exp_a_q.push_back({1'b1, 32'h400});
    exp_q.push_back(words[0]);
    check_logs("t5");
    chk("t5 done pulses", 64'(done_cnt), 64'd1);
    chk("t5 error held", 64'(error), 64'd1);
    chk("t5 done low", 64'(done), 64'd0);
    do_start(1'b0, 64'h1, 64'h2, 64'h3, 64'h4);
    chk("t5 error cleared", 64'(error), 64'd0);
    chk("t5 busy restart", 64'(busy), 64'd1);
    wait_done("t5b");
    chk("t5b result", result, 64'hBAD0_BAD0_BAD0_BAD0);
    repeat (2) cycle();

    // Asynchronous reset during WAIT, then no activity until a new start
    do_start(1'b1, 64'h5, 64'h6, 64'h7, 64'h8);
    repeat (7) cycle();
    chk("t6 in wait htrans", 64'(htrans), 64'd0);
    chk("t6 in wait busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("t6 async");
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    repeat (20) cycle();
    chk("t6 no transfers", 64'(addr_log.size()), 64'd0);
    chk("t6 busy idle", 64'(busy), 64'd0);
    chk("t6 no done", 64'(done_cnt), 64'd0);
    chk("t6 htrans idle", 64'(htrans), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ahb_lite_des_master.md
AHB_LITE_DES_MASTER -- requirements
Module: ahb_lite_des_master

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 20, meaning idle cycles between the last write data phase and the result read address phase (legal range 1..255).
REQ-002 SHALL have HCLK  in  1  sole clock, rising edge.
REQ-003 SHALL have HRESET  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have start  in  1  request one Triple DES operation.
REQ-005 SHALL have encryptionType  in  1  mode bit, sent on HWDATA[0].
REQ-006 SHALL have key1, key2, key3  in  64 each  DES keys.
REQ-007 SHALL have dataIn  in  64  input block.
REQ-008 SHALL have busy  out  1  operation in progress.
REQ-009 SHALL have done  out  1  one-cycle completion pulse.
REQ-010 SHALL have error  out  1  last operation ended on an error response, valid with done.
REQ-011 SHALL have result  out  64  read-back block, valid with done.
REQ-012 SHALL have the AHB-Lite master outputs HSEL 1, HADDR 32, HWRITE 1, HTRANS 2, HSIZE 3, HBURST 3, HPROT 4, HMASTLOCK 1, HWDATA 64.
REQ-013 SHALL have the AHB-Lite inputs HREADY 1, HRESP 1, HRDATA 64.

Function
REQ-014 SHALL tie HSIZE=3'b011, HBURST=3'b000, HPROT=4'h1, HMASTLOCK=0 at all times.
REQ-015 SHALL accept start only in IDLE and SHALL latch encryptionType, key1..3 and dataIn at that edge; start while busy is ignored.
REQ-016 SHALL use the states IDLE, WRITE, WAIT, RD_ADDR, RD_DATA and ERR.
REQ-017 In WRITE, SHALL issue five single NONSEQ write beats to 0x0000_0000 ({63'b0, encryptionType}), 0x0000_0400 (key1), 0x0000_0800 (key2), 0x0000_0C00 (key3) and 0x0000_1000 (dataIn).
REQ-018 SHALL pipeline the beats: beat k+1 address phase coincides with beat k data phase; HWDATA carries beat k word during its data phase.
REQ-019 SHALL advance the address and data phases only on edges where HREADY=1; while HREADY=0, HADDR, HTRANS, HWRITE and HWDATA SHALL hold.
REQ-020 SHALL drive HTRANS=IDLE (2'b00) and HSEL=0 in every cycle without an address phase; HSEL SHALL be 1 exactly when HTRANS=NONSEQ.
REQ-021 After the beat-4 data phase completes, SHALL enter WAIT and count WAIT_CYCLES cycles with HTRANS=IDLE.
REQ-022 RD_ADDR SHALL drive one NONSEQ read of 0x0000_1000 with HWRITE=0.
REQ-023 RD_DATA SHALL capture HRDATA into result on the first edge with HREADY=1, then pulse done=1 with error=0, clear busy and return to IDLE.
REQ-024 busy SHALL be 1 from the edge after start is accepted until the edge on which done is set.
REQ-025 On HRESP=1 with HREADY=0 (first error cycle), SHALL drive HTRANS=IDLE next cycle, cancel all pending beats and enter ERR.
REQ-026 ERR SHALL wait for HREADY=1, then pulse done=1 with error=1; result SHALL keep its previous value; then return to IDLE.
REQ-027 error SHALL hold its value until the next accepted start, which clears it.
REQ-028 start coinciding with done SHALL be ignored; a new operation needs start in IDLE with done=0.

Reset
REQ-029 While HRESET=0, SHALL force state=IDLE, HTRANS=2'b00, HSEL=0, HADDR=0, HWRITE=0, HWDATA=0, busy=0, done=0, error=0, result=0 and the beat and wait counters to 0.
REQ-030 Reset asserted mid-operation SHALL abort immediately; after release the block SHALL remain IDLE until the next start.

Verification
REQ-031 WAIT_CYCLES=4, HREADY=1, start at edge E0 -> NONSEQ write addresses 0x0, 0x400, 0x800, 0xC00, 0x1000 on cycles after E0..E4; HWDATA words on cycles after E1..E5; read of 0x1000 in the cycle after E10; result=HRDATA sampled at E12; done=1 for the cycle after E12.
REQ-032 key2=64'hA5A5_0000_FFFF_1234 and HREADY=0 for 3 cycles during the 0x800 data phase -> HADDR=0xC00 and HWDATA=64'hA5A5_0000_FFFF_1234 held stable for all 3 cycles, and the sequence then resumes intact.
REQ-033 Slave returns a two-cycle ERROR response on the 0x400 beat -> HTRANS=IDLE in the second error cycle; no 0x800/0xC00/0x1000 transfers; done=1 with error=1; result unchanged.
REQ-034 start pulsed again while busy=1 -> ignored; exactly one 5-write/1-read sequence and one done pulse.
REQ-035 HRESET low during WAIT -> all outputs reach REQ-029 values without a clock edge; no read is issued after release until a new start.
